// File: rtl/shared_pkg.sv
// Types and default sizing shared by the FIFO family.
package shared_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port and one asynchronous read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with selectable STD/FWFT read mode, programmable
// almost-full/almost-empty thresholds, occupancy count and synchronous flush.
module sync_fifo_prog
  import shared_pkg::*;
#(
  parameter int         DATA_WIDTH = FIFO_WIDTH,
  parameter int         DEPTH      = FIFO_DEPTH,
  parameter fifo_mode_e MODE       = FIFO_STD,
  localparam int        CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic [CNT_W-1:0]      af_level,
  input  logic [CNT_W-1:0]      ae_level,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  wr_ack_reg, wr_ack_next;
  logic                  overflow_reg, overflow_next;
  logic                  underflow_reg, underflow_next;
  logic                  rd_ok, wr_ok;
  logic                  mem_we, pop;
  logic [DATA_WIDTH-1:0] rdata;

  assign full        = (count_reg == FULL_CNT);
  assign empty       = (count_reg == '0);
  assign almostfull  = (af_level != '0) && (count_reg >= af_level);
  assign almostempty = (count_reg <= ae_level);
  assign count       = count_reg;
  assign wr_ack      = wr_ack_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write.
  assign rd_ok  = rd_en && !empty;
  assign wr_ok  = wr_en && (!full || rd_ok);
  assign mem_we = wr_ok && !flush && !rst;
  assign pop    = rd_ok && !flush;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    wr_ack_next    = 1'b0;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // Explicit wrap keeps non-power-of-2 depths correct.
      if (wr_ok) begin
        wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
      wr_ack_next    = wr_ok;
      overflow_next  = wr_en && !wr_ok;
      underflow_next = rd_en && !rd_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      wr_ack_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      wr_ack_reg    <= wr_ack_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_reg),
    .wdata (data_in),
    .raddr (rd_ptr_reg),
    .rdata (rdata)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] data_out_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_out_reg <= '0;
      end else if (pop) begin
        data_out_reg <= rdata;
      end
    end

    assign data_out = data_out_reg;
  end else begin : g_fwft
    // Head word is shown directly; zero while nothing is stored.
    assign data_out = empty ? '0 : rdata;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives an STD and an FWFT instance with identical stimulus and checks both
// against a queue-based reference model.
module tb_sync_fifo_prog;
  import shared_pkg::*;

  localparam int W     = 16;
  localparam int D     = 8;
  localparam int CNT_W = $clog2(D + 1);

  logic             clk = 1'b0;
  logic             rst, wr_en, rd_en, flush;
  logic [W-1:0]     data_in;
  logic [CNT_W-1:0] af_level, ae_level;

  logic [W-1:0]     s_dout, f_dout;
  logic             s_ack, s_ovf, s_unf, s_full, s_empty, s_af, s_ae;
  logic             f_ack, f_ovf, f_unf, f_full, f_empty, f_af, f_ae;
  logic [CNT_W-1:0] s_cnt, f_cnt;

  // Reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] m_std_dout;
  logic         m_ack, m_ovf, m_unf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(W), .DEPTH(D), .MODE(FIFO_STD)) u_std (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .flush(flush), .af_level(af_level), .ae_level(ae_level),
    .data_out(s_dout), .wr_ack(s_ack), .overflow(s_ovf), .underflow(s_unf),
    .full(s_full), .empty(s_empty), .almostfull(s_af), .almostempty(s_ae),
    .count(s_cnt)
  );

  sync_fifo_prog #(.DATA_WIDTH(W), .DEPTH(D), .MODE(FIFO_FWFT)) u_fwft (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .flush(flush), .af_level(af_level), .ae_level(ae_level),
    .data_out(f_dout), .wr_ack(f_ack), .overflow(f_ovf), .underflow(f_unf),
    .full(f_full), .empty(f_empty), .almostfull(f_af), .almostempty(f_ae),
    .count(f_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the current inputs to the model as the clock edge would.
  task automatic model_edge();
    bit rd_ok, wr_ok;
    if (rst) begin
      q.delete();
      m_std_dout = '0;
      m_ack = 0; m_ovf = 0; m_unf = 0;
    end else if (flush) begin
      q.delete();
      m_ack = 0; m_ovf = 0; m_unf = 0;
    end else begin
      rd_ok = rd_en && (q.size() > 0);
      wr_ok = wr_en && ((q.size() < D) || rd_ok);
      if (rd_ok) m_std_dout = q.pop_front();
      if (wr_ok) q.push_back(data_in);
      m_ack = wr_ok;
      m_ovf = wr_en && !wr_ok;
      m_unf = rd_en && !rd_ok;
    end
  endtask

  task automatic check_all(input string step);
    int n;
    logic exp_af, exp_ae;
    logic [W-1:0] exp_f;
    n = q.size();
    exp_af = (af_level != 0) && (n >= int'(af_level));
    exp_ae = (n <= int'(ae_level));
    exp_f = (n > 0) ? q[0] : '0;
    chk({step, ".std.count"}, 32'(s_cnt), 32'(n));
    chk({step, ".std.empty"}, 32'(s_empty), 32'(n == 0));
    chk({step, ".std.full"}, 32'(s_full), 32'(n == D));
    chk({step, ".std.af"}, 32'(s_af), 32'(exp_af));
    chk({step, ".std.ae"}, 32'(s_ae), 32'(exp_ae));
    chk({step, ".std.wr_ack"}, 32'(s_ack), 32'(m_ack));
    chk({step, ".std.overflow"}, 32'(s_ovf), 32'(m_ovf));
    chk({step, ".std.underflow"}, 32'(s_unf), 32'(m_unf));
    chk({step, ".std.data_out"}, 32'(s_dout), 32'(m_std_dout));
    chk({step, ".fwft.count"}, 32'(f_cnt), 32'(n));
    chk({step, ".fwft.empty"}, 32'(f_empty), 32'(n == 0));
    chk({step, ".fwft.full"}, 32'(f_full), 32'(n == D));
    chk({step, ".fwft.af"}, 32'(f_af), 32'(exp_af));
    chk({step, ".fwft.ae"}, 32'(f_ae), 32'(exp_ae));
    chk({step, ".fwft.wr_ack"}, 32'(f_ack), 32'(m_ack));
    chk({step, ".fwft.overflow"}, 32'(f_ovf), 32'(m_ovf));
    chk({step, ".fwft.underflow"}, 32'(f_unf), 32'(m_unf));
    chk({step, ".fwft.data_out"}, 32'(f_dout), 32'(exp_f));
  endtask

  // One clock transaction: drive, clock, update model, sample 1 time unit later.
  task automatic step(input string name, input logic r, input logic fl,
                      input logic w, input logic rd, input logic [W-1:0] din);
    rst = r; flush = fl; wr_en = w; rd_en = rd; data_in = din;
    @(posedge clk);
    model_edge();
    #1;
    check_all(name);
    $display("%s rst=%0b flush=%0b wr=%0b rd=%0b din=%04h -> count=%0d std_out=%04h fwft_out=%04h",
             name, r, fl, w, rd, din, s_cnt, s_dout, f_dout);
  endtask

  initial begin
    m_std_dout = '0; m_ack = 0; m_ovf = 0; m_unf = 0;
    af_level = CNT_W'(6);
    ae_level = CNT_W'(2);
    rst = 1; flush = 0; wr_en = 0; rd_en = 0; data_in = '0;
    @(negedge clk);

    // Reset while a write is requested: nothing must be stored.
    step("reset_wr", 1, 0, 1, 0, 16'h0003);
    step("idle", 0, 0, 0, 0, 16'h0000);

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 8; i++) step("fill", 0, 0, 1, 0, W'(i));
    step("overflow", 0, 0, 1, 0, 16'h0009);
    for (int i = 0; i < 8; i++) step("drain", 0, 0, 0, 1, 16'h0000);
    step("idle", 0, 0, 0, 0, 16'h0000);

    // Simultaneous read/write at full, then drain through the wrap.
    for (int i = 1; i <= 8; i++) step("refill", 0, 0, 1, 0, W'(i));
    step("full_rw", 0, 0, 1, 1, 16'h00AA);
    for (int i = 0; i < 8; i++) step("drain_wrap", 0, 0, 0, 1, 16'h0000);

    // Empty-FIFO reads.
    step("underflow", 0, 0, 0, 1, 16'h0000);
    step("empty_rw", 0, 0, 1, 1, 16'h0055);
    step("pop", 0, 0, 0, 1, 16'h0000);

    // Thresholds; flags are checked on every step.
    for (int i = 0; i < 6; i++) step("af_fill", 0, 0, 1, 0, W'(16'h0100 + i));
    for (int i = 0; i < 4; i++) step("ae_drain", 0, 0, 0, 1, 16'h0000);
    af_level = '0;
    for (int i = 0; i < 6; i++) step("af_off", 0, 0, 1, 0, W'(16'h0200 + i));
    af_level = CNT_W'(D + 3);
    step("af_high", 0, 0, 1, 1, 16'h0300);
    af_level = CNT_W'(6);

    // Flush empties the FIFO and ignores the same-cycle write.
    for (int i = 0; i < 8; i++) step("to_empty", 0, 0, 0, 1, 16'h0000);
    step("fwft_wr", 0, 0, 1, 0, 16'h1234);
    step("fwft_pop", 0, 0, 0, 1, 16'h0000);
    for (int i = 0; i < 5; i++) step("pre_flush", 0, 0, 1, 0, W'(16'h0400 + i));
    step("flush", 0, 1, 1, 0, 16'h0777);
    step("post_flush", 0, 0, 0, 0, 16'h0000);

    // Reset in the middle of a burst.
    for (int i = 0; i < 3; i++) step("burst", 0, 0, 1, 0, W'(16'h0500 + i));
    step("reset_mid", 1, 0, 1, 1, 16'h0600);
    step("after_rst", 0, 0, 0, 1, 16'h0000);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        af_level = CNT_W'($urandom_range(0, 10));
        ae_level = CNT_W'($urandom_range(0, 10));
      end
      step("rand", ($urandom_range(0, 59) == 0), ($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
